// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game controller slice:
//   - game_state_e : controller phase encoding
//   - DEF_*        : default parameter values (25 MHz system clock)
//   - LIVES_W      : width of the lives counter
//   - lives_dec_sat: saturating decrement of the lives counter
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    ST_READY = 3'd0,
    ST_START = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DEAD  = 3'd4,
    ST_OVER  = 3'd5
  } game_state_e;

  // 10 ms debounce at 25 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  // 60 Hz motion tick at 25 MHz
  localparam int DEF_TICK_DIV        = 416667;
  localparam int DEF_LIVES_INIT      = 3;
  // 1 s auto-serve wait at 25 MHz
  localparam int DEF_SERVE_DELAY     = 25000000;

  localparam int LIVES_W = 2;

  // Decrement lives, holding at zero
  function automatic logic [LIVES_W-1:0] lives_dec_sat(input logic [LIVES_W-1:0] lives);
    if (lives == {LIVES_W{1'b0}}) begin
      return {LIVES_W{1'b0}};
    end else begin
      return lives - LIVES_W'(1);
    end
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// game_ctrl_fsm_if
// Signal bundle between the game controller and its surroundings.
//   key_*_n          raw active-low pushbuttons (asynchronous)
//   sig_dead         single-cycle miss pulse from the datapath
//   ready/start/play/pause_sig  phase controls to the datapath
//   left_sig/right_sig          paddle move levels
//   game_clk         single-cycle motion tick
//   lives            remaining lives
//   game_over        high while the game is over
// Modports:
//   master : the board/datapath side (drives keys and sig_dead)
//   slave  : the controller (drives phase, move, tick and status outputs)
// -----------------------------------------------------------------------------
interface game_ctrl_fsm_if;
  import game_pkg::*;

  logic               key_start_n;
  logic               key_pause_n;
  logic               key_left_n;
  logic               key_right_n;
  logic               sig_dead;
  logic               ready_sig;
  logic               start_sig;
  logic               play_sig;
  logic               pause_sig;
  logic               left_sig;
  logic               right_sig;
  logic               game_clk;
  logic [LIVES_W-1:0] lives;
  logic               game_over;

  modport master (
    output key_start_n, key_pause_n, key_left_n, key_right_n, sig_dead,
    input  ready_sig, start_sig, play_sig, pause_sig,
    input  left_sig, right_sig, game_clk, lives, game_over
  );

  modport slave (
    input  key_start_n, key_pause_n, key_left_n, key_right_n, sig_dead,
    output ready_sig, start_sig, play_sig, pause_sig,
    output left_sig, right_sig, game_clk, lives, game_over
  );

endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser, inversion to active-high and debounce for one raw
// active-low pushbutton.
//   clk, reset   system clock, asynchronous active-high reset
//   key_n_i      raw active-low key (asynchronous to clk)
//   key_level_o  debounced active-high level
//   key_press_o  one-cycle pulse on each debounced press
// The debounced level only changes after the synchronised key has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
// -----------------------------------------------------------------------------
module key_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic key_level_o,
  output logic key_press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q;
  logic             sync2_q;
  logic             key_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;

  // Synchroniser flops. They reset to the "pressed" raw level so that a key
  // held across reset release is never mistaken for a fresh press: the key
  // has to be seen released before its next rising edge is reported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = ~sync2_q;

  // Mismatch counter, debounced level, arming and press pulse
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    armed_d = armed_q;
    press_d = 1'b0;
    if (key_s != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_d   = {CNT_W{1'b0}};
        level_d = key_s;
        press_d = key_s & armed_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
    // A confirmed released state enables press reporting from then on
    if (!key_s && !level_q) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= {CNT_W{1'b0}};
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign key_level_o = level_q;
  assign key_press_o = press_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// game_ctrl_fsm
// Phase controller for a paddle game: debounces the four pushbuttons, runs
// the READY/START/PLAY/PAUSE/DEAD/OVER phase machine, keeps the lives count,
// generates the motion tick and gates the paddle move levels.
//   clk    system/pixel clock
//   reset  asynchronous, active-high
//   bus    game_ctrl_fsm_if.slave: raw keys and sig_dead in; phase controls,
//          move levels, game_clk, lives and game_over out (all registered)
// Optional build macro GAME_AUTO_SERVE_EN: READY reached from DEAD serves
// automatically after SERVE_DELAY cycles unless a start press comes first.
// Without the macro READY only leaves on a start press.
// -----------------------------------------------------------------------------
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEF_TICK_DIV,
  parameter int LIVES_INIT      = DEF_LIVES_INIT,
  parameter int SERVE_DELAY     = DEF_SERVE_DELAY
) (
  input  logic          clk,
  input  logic          reset,
  game_ctrl_fsm_if.slave bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic       start_press_s;
  logic       pause_press_s;
  logic       left_lvl_s;
  logic       right_lvl_s;
  logic [1:0] unused_lvl_s;
  logic [1:0] unused_press_s;

  game_state_e        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic               game_clk_q, game_clk_d;
  logic               ready_q, ready_d;
  logic               start_q, start_d;
  logic               play_q, play_d;
  logic               pause_q, pause_d;
  logic               left_q, left_d;
  logic               right_q, right_d;
  logic               over_q, over_d;

`ifdef GAME_AUTO_SERVE_EN
  localparam int SERVE_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  logic               serve_arm_q, serve_arm_d;
  logic [SERVE_W-1:0] serve_cnt_q, serve_cnt_d;
`endif

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
    .clk        (clk),
    .reset      (reset),
    .key_n_i    (bus.key_start_n),
    .key_level_o(unused_lvl_s[0]),
    .key_press_o(start_press_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_pause (
    .clk        (clk),
    .reset      (reset),
    .key_n_i    (bus.key_pause_n),
    .key_level_o(unused_lvl_s[1]),
    .key_press_o(pause_press_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_left (
    .clk        (clk),
    .reset      (reset),
    .key_n_i    (bus.key_left_n),
    .key_level_o(left_lvl_s),
    .key_press_o(unused_press_s[0])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_right (
    .clk        (clk),
    .reset      (reset),
    .key_n_i    (bus.key_right_n),
    .key_level_o(right_lvl_s),
    .key_press_o(unused_press_s[1])
  );

  // Next phase, lives bookkeeping and auto-serve timing
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
`ifdef GAME_AUTO_SERVE_EN
    serve_arm_d = serve_arm_q;
    serve_cnt_d = serve_cnt_q;
`endif
    case (state_q)
      ST_READY: begin
        if (start_press_s) begin
          state_d = ST_START;
        end
`ifdef GAME_AUTO_SERVE_EN
        else if (serve_arm_q && (serve_cnt_q == SERVE_W'(SERVE_DELAY - 1))) begin
          state_d = ST_START;
        end else if (serve_arm_q) begin
          serve_cnt_d = serve_cnt_q + SERVE_W'(1);
        end
`endif
        else begin
          state_d = ST_READY;
        end
      end
      ST_START: begin
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // A miss wins over a simultaneous pause press
        if (bus.sig_dead) begin
          state_d = ST_DEAD;
          lives_d = lives_dec_sat(lives_q);
        end else if (pause_press_s) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PAUSE: begin
        if (pause_press_s) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DEAD: begin
        // lives was already decremented on entry, so zero means the last life
        if (lives_q == {LIVES_W{1'b0}}) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_READY;
`ifdef GAME_AUTO_SERVE_EN
          serve_arm_d = 1'b1;
          serve_cnt_d = {SERVE_W{1'b0}};
`endif
        end
      end
      ST_OVER: begin
        if (start_press_s) begin
          state_d = ST_READY;
          lives_d = LIVES_W'(LIVES_INIT);
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
`ifdef GAME_AUTO_SERVE_EN
    if (state_d == ST_START) begin
      serve_arm_d = 1'b0;
      serve_cnt_d = {SERVE_W{1'b0}};
    end else begin
      serve_arm_d = serve_arm_d;
    end
`endif
  end

  // Motion tick: counts only while playing, frozen otherwise, cleared on serve
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    game_clk_d = 1'b0;
    if (state_d == ST_START) begin
      tick_cnt_d = {TICK_W{1'b0}};
    end else if (state_q == ST_PLAY) begin
      if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
        tick_cnt_d = {TICK_W{1'b0}};
        game_clk_d = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  // Registered output values decoded from the next phase
  always_comb begin
    ready_d = (state_d == ST_READY);
    start_d = (state_d == ST_START);
    play_d  = (state_d == ST_PLAY) || (state_d == ST_PAUSE);
    pause_d = (state_d == ST_PAUSE);
    over_d  = (state_d == ST_OVER);
    // Both move keys held cancel each other
    left_d  = (state_d == ST_PLAY) && left_lvl_s && !right_lvl_s;
    right_d = (state_d == ST_PLAY) && right_lvl_s && !left_lvl_s;
  end

  // Phase, lives, tick and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_READY;
      lives_q    <= LIVES_W'(LIVES_INIT);
      tick_cnt_q <= {TICK_W{1'b0}};
      game_clk_q <= 1'b0;
      ready_q    <= 1'b1;
      start_q    <= 1'b0;
      play_q     <= 1'b0;
      pause_q    <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      tick_cnt_q <= tick_cnt_d;
      game_clk_q <= game_clk_d;
      ready_q    <= ready_d;
      start_q    <= start_d;
      play_q     <= play_d;
      pause_q    <= pause_d;
      left_q     <= left_d;
      right_q    <= right_d;
      over_q     <= over_d;
    end
  end

`ifdef GAME_AUTO_SERVE_EN
  // Auto-serve wait registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      serve_arm_q <= 1'b0;
      serve_cnt_q <= {SERVE_W{1'b0}};
    end else begin
      serve_arm_q <= serve_arm_d;
      serve_cnt_q <= serve_cnt_d;
    end
  end
`endif

  assign bus.ready_sig = ready_q;
  assign bus.start_sig = start_q;
  assign bus.play_sig  = play_q;
  assign bus.pause_sig = pause_q;
  assign bus.left_sig  = left_q;
  assign bus.right_sig = right_q;
  assign bus.game_clk  = game_clk_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = over_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl_fsm
// Directed scenarios followed by randomized key/miss stimulus. Every cycle the
// packed DUT outputs are compared with a behavioural model of the game rules.
// -----------------------------------------------------------------------------
module tb_game_ctrl_fsm;

  localparam int DEB   = 4;
  localparam int TDIV  = 8;
  localparam int LIVES = 3;
  localparam int SDLY  = 20;
`ifdef GAME_AUTO_SERVE_EN
  localparam bit SERVE_ON = 1'b1;
`else
  localparam bit SERVE_ON = 1'b0;
`endif

  localparam int P_READY = 0, P_START = 1, P_PLAY = 2, P_PAUSE = 3, P_DEAD = 4, P_OVER = 5;

  logic clk = 1'b0;
  logic reset;
  game_ctrl_fsm_if bus ();

  game_ctrl_fsm #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_DIV       (TDIV),
    .LIVES_INIT     (LIVES),
    .SERVE_DELAY    (SDLY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n_start = 0;
  int n_tick  = 0;

  // stimulus: index 0 start, 1 pause, 2 left, 3 right (raw, active-low)
  bit k_n[4];
  bit dead_in;

  // model state
  int m_phase, m_lives, m_play_cnt, m_serve;
  bit m_lvl[4], m_armed[4], m_press[4];
  int m_run[4];
  bit m_pipe[4][2];
  bit [9:0] m_out;
  bit [9:0] rst_vec;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_out();
    return {bus.ready_sig, bus.start_sig, bus.play_sig, bus.pause_sig, bus.left_sig,
            bus.right_sig, bus.game_clk, bus.lives, bus.game_over};
  endfunction

  task automatic model_reset();
    m_phase = P_READY; m_lives = LIVES; m_play_cnt = 0; m_serve = -1;
    for (int i = 0; i < 4; i++) begin
      m_lvl[i] = 1'b0; m_armed[i] = 1'b0; m_press[i] = 1'b0; m_run[i] = 0;
      m_pipe[i][0] = 1'b1; m_pipe[i][1] = 1'b1;
    end
    m_out = rst_vec;
  endtask

  // One clock edge of the game rules applied to the pre-edge inputs
  task automatic model_step();
    bit old_lvl[4];
    bit old_press[4];
    bit ks, gclk;
    int np;
    for (int i = 0; i < 4; i++) begin
      old_lvl[i] = m_lvl[i];
      old_press[i] = m_press[i];
    end
    for (int i = 0; i < 4; i++) begin
      ks = m_pipe[i][0];
      m_pipe[i][0] = m_pipe[i][1];
      m_pipe[i][1] = ~k_n[i];
      m_press[i] = 1'b0;
      if (ks != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = ks; m_run[i] = 0; m_press[i] = ks && m_armed[i];
        end
      end else begin
        m_run[i] = 0;
      end
      if (!ks && !old_lvl[i]) m_armed[i] = 1'b1;
    end
    np = m_phase; gclk = 1'b0;
    case (m_phase)
      P_READY: begin
        if (old_press[0]) np = P_START;
        else if (m_serve >= 0) begin
          m_serve++;
          if (m_serve == SDLY) np = P_START;
        end
      end
      P_START: np = P_PLAY;
      P_PLAY: begin
        m_play_cnt++;
        gclk = (m_play_cnt % TDIV) == 0;
        if (dead_in) begin
          np = P_DEAD; m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        end else if (old_press[1]) np = P_PAUSE;
      end
      P_PAUSE: if (old_press[1]) np = P_PLAY;
      P_DEAD: begin
        if (m_lives == 0) np = P_OVER;
        else begin
          np = P_READY;
          if (SERVE_ON) m_serve = 0;
        end
      end
      P_OVER: if (old_press[0]) begin np = P_READY; m_lives = LIVES; end
      default: np = P_READY;
    endcase
    if (np == P_START) begin m_play_cnt = 0; m_serve = -1; end
    m_phase = np;
    m_out = {np == P_READY, np == P_START, np == P_PLAY || np == P_PAUSE, np == P_PAUSE,
             np == P_PLAY && old_lvl[2] && !old_lvl[3], np == P_PLAY && old_lvl[3] && !old_lvl[2],
             gclk, 2'(m_lives), np == P_OVER};
  endtask

  task automatic cycle(input int n);
    for (int c = 0; c < n; c++) begin
      bus.key_start_n = k_n[0]; bus.key_pause_n = k_n[1];
      bus.key_left_n  = k_n[2]; bus.key_right_n = k_n[3];
      bus.sig_dead    = dead_in;
      @(posedge clk);
      model_step();
      #1;
      check_val("outs", 32'(dut_out()), 32'(m_out));
      if (bus.start_sig) n_start++;
      if (bus.game_clk) n_tick++;
    end
  endtask

  task automatic press_key(input int idx);
    k_n[idx] = 1'b0; cycle(DEB + 4);
    k_n[idx] = 1'b1; cycle(DEB + 4);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic do_reset();
    #3; reset = 1'b1; #1;
    check_val("rst_async", 32'(dut_out()), 32'(rst_vec));
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int first, hold[4];
    bit found;
    rst_vec = {1'b1, 6'b0, 2'(LIVES), 1'b0};
    for (int i = 0; i < 4; i++) k_n[i] = 1'b1;
    dead_in = 1'b0;
    bus.key_start_n = 1'b1; bus.key_pause_n = 1'b1;
    bus.key_left_n = 1'b1; bus.key_right_n = 1'b1; bus.sig_dead = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("rst_init", 32'(dut_out()), 32'(rst_vec));
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(4);

    // bouncy start press: exactly one single-cycle start pulse, then PLAY
    n_start = 0;
    k_n[0] = 1'b0; cycle(2); k_n[0] = 1'b1; cycle(1); k_n[0] = 1'b0; cycle(10);
    k_n[0] = 1'b1; cycle(8);
    check_val("start_once", 32'(n_start), 32'd1);
    check_val("play_after_start", 32'(bus.play_sig), 32'd1);

    // ticks every TDIV cycles, frozen in pause, resumed afterwards
    n_tick = 0; cycle(32);
    check_val("tick_rate", 32'(n_tick), 32'd4);
    press_key(1);
    n_tick = 0; cycle(24);
    check_val("pause_no_tick", 32'(n_tick), 32'd0);
    check_val("pause_sig", 32'(bus.pause_sig), 32'd1);
    press_key(1);
    n_tick = 0; cycle(32);
    check_val("tick_resume", 32'(n_tick), 32'd4);

    // miss and pause press on the same edge: miss wins
    k_n[1] = 1'b0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1);
      found = m_press[1];
    end
    check_val("pause_press_seen", 32'(found), 32'd1);
    dead_in = 1'b1; cycle(1); dead_in = 1'b0;
    check_val("dead_not_pause", 32'({bus.play_sig, bus.pause_sig}), 32'd0);
    check_val("dead_lives", 32'(bus.lives), 32'd2);
    cycle(1);
    check_val("dead_to_ready", 32'(bus.ready_sig), 32'd1);
    k_n[1] = 1'b1; cycle(10);

    // both move keys cancel, one key alone passes
    press_key(0);
    check_val("play_again", 32'(bus.play_sig), 32'd1);
    k_n[2] = 1'b0; k_n[3] = 1'b0; cycle(12);
    check_val("both_keys", 32'({bus.left_sig, bus.right_sig}), 32'd0);
    k_n[3] = 1'b1; cycle(10);
    check_val("left_only", 32'({bus.left_sig, bus.right_sig}), 32'd2);
    k_n[2] = 1'b1; cycle(10);

    // run out of lives, then restart from OVER
    dead_in = 1'b1; cycle(1); dead_in = 1'b0;
    check_val("life_1", 32'(bus.lives), 32'd1);
    cycle(1);
    press_key(0);
    dead_in = 1'b1; cycle(1); dead_in = 1'b0;
    check_val("life_0", 32'(bus.lives), 32'd0);
    cycle(1);
    check_val("over", 32'(bus.game_over), 32'd1);
    press_key(0);
    check_val("reload_ready", 32'({bus.ready_sig, bus.lives}), 32'({1'b1, 2'(LIVES)}));

    // READY after a miss: auto-serve only with the macro
    press_key(0);
    dead_in = 1'b1; cycle(1); dead_in = 1'b0;
    cycle(1);
    first = 0;
    for (int k = 1; k <= 25; k++) begin
      cycle(1);
      if (bus.start_sig && first == 0) first = k;
    end
`ifdef GAME_AUTO_SERVE_EN
    check_val("serve_latency", 32'(first), 32'(SDLY));
`else
    check_val("serve_latency", 32'(first), 32'd0);
    check_val("stay_ready", 32'(bus.ready_sig), 32'd1);
`endif

    // reset mid-PLAY, then a start key held through reset release
    press_key(0);
    cycle(3);
    do_reset();
    k_n[0] = 1'b0;
    do_reset();
    n_start = 0; cycle(20);
    check_val("held_through_reset", 32'(n_start), 32'd0);
    k_n[0] = 1'b1; cycle(10);
    press_key(0);
    check_val("press_after_release", 32'(n_start), 32'd1);

    // randomized keys and misses against the model
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          k_n[i] = ($urandom_range(0, 99) < ((i < 2) ? 25 : 40)) ? 1'b0 : 1'b1;
          hold[i] = $urandom_range(1, 14);
        end else begin
          hold[i]--;
        end
      end
      dead_in = ($urandom_range(0, 39) == 0);
      if (c == 1500) do_reset();
      cycle(1);
    end
    dead_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
